// File: rtl/vector_rf_fill_if.sv
// Port bundle for the vector register file: three read ports, the masked
// vector write port and the lane-serial fill handshake.
interface vector_rf_fill_if #(
  parameter int LANES = 16,
  parameter int LW    = 16,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
);
  logic [AW-1:0]              rs1, rs2, rs3;
  logic [LANES-1:0][LW-1:0]   rd1, rd2, rd3;
  logic                       we;
  logic [AW-1:0]              wa;
  logic [LANES-1:0]           wmask;
  logic [LANES-1:0][LW-1:0]   wd;
  logic                       fill_start;
  logic [AW-1:0]              fill_reg;
  logic                       fill_valid;
  logic [LW-1:0]              fill_data;
  logic                       fill_ready, fill_busy, fill_done;

  modport master (
    output rs1, rs2, rs3, we, wa, wmask, wd,
           fill_start, fill_reg, fill_valid, fill_data,
    input  rd1, rd2, rd3, fill_ready, fill_busy, fill_done
  );
  modport slave (
    input  rs1, rs2, rs3, we, wa, wmask, wd,
           fill_start, fill_reg, fill_valid, fill_data,
    output rd1, rd2, rd3, fill_ready, fill_busy, fill_done
  );
endinterface

// File: rtl/vector_rf_fill.sv
// Vector register file, one lane column per instance, with masked vector write
// (bypassed to reads) and a lane-serial fill FSM for the memory load path.

module vector_rf_lane #(
  parameter int NREGS = 32,
  parameter int LW    = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vwe,
  input  logic [AW-1:0]        vwa,
  input  logic [LW-1:0]        vwd,
  input  logic                 fwe,
  input  logic [AW-1:0]        fwa,
  input  logic [LW-1:0]        fwd,
  input  logic [2:0][AW-1:0]   ra,
  output logic [2:0][LW-1:0]   rdat
);
  localparam logic [AW:0] NREGS_W = NREGS[AW:0];

  logic [NREGS-1:0][LW-1:0] regs;

  // Vector write has priority over a fill beat landing on the same cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (vwe && vwa == AW'(r))      regs[r] <= vwd;
        else if (fwe && fwa == AW'(r)) regs[r] <= fwd;
      end
    end
  end

  always_comb begin
    rdat = '0;
    for (int p = 0; p < 3; p++) begin
      if ({1'b0, ra[p]} < NREGS_W) begin
        rdat[p] = regs[ra[p]];
        if (vwe && vwa == ra[p]) rdat[p] = vwd;
      end
    end
  end
endmodule

module vector_rf_fill #(
  parameter int LANES = 16,
  parameter int LW    = 16,
  parameter int NREGS = 32
) (
  input logic             clk,
  input logic             rst,
  vector_rf_fill_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t              st;
  logic [CW-1:0]       cnt;
  logic [AW-1:0]       freg;
  logic                ready_q, busy_q, done_q;
  logic                fwe;
  logic [2:0][AW-1:0]  ra;
  logic [LANES-1:0][2:0][LW-1:0] lane_rd;

  // Status outputs are registered alongside the state, so fill_valid never
  // reaches fill_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      freg    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (st)
        IDLE: if (bus.fill_start) begin
          freg    <= bus.fill_reg;
          cnt     <= '0;
          st      <= FILL;
          ready_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        FILL: if (bus.fill_valid) begin
          if (cnt == CW'(LANES-1)) begin
            st      <= DONE;
            ready_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          st     <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign fwe = (st == FILL) && bus.fill_valid;
  assign ra  = {bus.rs3, bus.rs2, bus.rs1};

  assign bus.fill_ready = ready_q;
  assign bus.fill_busy  = busy_q;
  assign bus.fill_done  = done_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vector_rf_lane #(.NREGS(NREGS), .LW(LW), .AW(AW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .vwe  (bus.we && bus.wmask[i]),
      .vwa  (bus.wa),
      .vwd  (bus.wd[i]),
      .fwe  (fwe && cnt == CW'(i)),
      .fwa  (freg),
      .fwd  (bus.fill_data),
      .ra   (ra),
      .rdat (lane_rd[i])
    );
    assign bus.rd1[i] = lane_rd[i][0];
    assign bus.rd2[i] = lane_rd[i][1];
    assign bus.rd3[i] = lane_rd[i][2];
  end
endmodule

// File: tb/tb_vector_rf_fill.sv
// Directed bench for vector_rf_fill: reset, bypass, fill handshake, collisions,
// reset abort and fill_start held high.
module tb_vector_rf_fill;
  typedef logic [15:0][15:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  vector_rf_fill_if #(.LANES(16), .LW(16), .NREGS(32)) bus ();
  vector_rf_fill #(.LANES(16), .LW(16), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] r, input vec_t exp);
    bus.rs3 = r; #1;
    chk(tag, bus.rd3, exp);
  endtask

  task automatic start_fill(input logic [4:0] r);
    bus.fill_start = 1'b1; bus.fill_reg = r;
    tick();
    bus.fill_start = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d);
    bus.fill_valid = 1'b1; bus.fill_data = d;
    tick();
    bus.fill_valid = 1'b0;
  endtask

  vec_t exp_v;

  initial begin
    bus.rs1 = 5'd0; bus.rs2 = 5'd5; bus.rs3 = 5'd31;
    bus.we = 1'b0; bus.wa = '0; bus.wmask = '0; bus.wd = '0;
    bus.fill_start = 1'b0; bus.fill_reg = '0; bus.fill_valid = 1'b0; bus.fill_data = '0;

    // 1: reset state
    #2;
    chk("rst_rd1", bus.rd1, '0);
    chk("rst_rd2", bus.rd2, '0);
    chk("rst_rd3", bus.rd3, '0);
    chk("rst_ready", bus.fill_ready, 0);
    chk("rst_busy",  bus.fill_busy, 0);
    chk("rst_done",  bus.fill_done, 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // 2: masked write with bypass
    bus.we = 1'b1; bus.wa = 5'd3; bus.wmask = 16'hFFFF; bus.wd = {16{16'h1111}};
    tick();
    bus.wmask = 16'h00FF; bus.wd = {16{16'hA5A5}}; bus.rs1 = 5'd3; #1;
    exp_v = {{8{16'h1111}}, {8{16'hA5A5}}};
    chk("bypass_rd1", bus.rd1, exp_v);
    tick();
    bus.we = 1'b0; #1;
    chk("stored_rd1", bus.rd1, exp_v);
    bus.we = 1'b1; bus.wmask = 16'h0000; bus.wd = '0;
    tick();
    bus.we = 1'b0;
    chk_reg("mask0_noop", 5'd3, exp_v);

    // 3: fill reg 7, valid on alternate cycles
    start_fill(5'd7);
    chk("fill_ready", bus.fill_ready, 1);
    chk("fill_busy", bus.fill_busy, 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      beat(16'(i));
      if (i == 7) begin
        exp_v = '0;
        for (int l = 0; l < 8; l++) exp_v[l] = 16'(l);
        chk_reg("partial_read", 5'd7, exp_v);
      end
      if (i == 14) chk("done_early", bus.fill_done, 0);
    end
    chk("done_pulse", bus.fill_done, 1);
    chk("done_not_ready", bus.fill_ready, 0);
    for (int l = 0; l < 16; l++) exp_v[l] = 16'(l);
    chk_reg("fill_reg7", 5'd7, exp_v);
    tick();
    chk("done_one_cycle", bus.fill_done, 0);
    chk("busy_clear", bus.fill_busy, 0);

    // 4: collisions during a refill of reg 7
    start_fill(5'd7);
    for (int i = 0; i < 16; i++) begin
      if (i == 4) begin
        bus.we = 1'b1; bus.wa = 5'd7; bus.wmask = 16'h0010; bus.wd = '0; bus.wd[4] = 16'hBEEF;
      end else if (i == 6) begin
        bus.we = 1'b1; bus.wa = 5'd7; bus.wmask = 16'h0004; bus.wd = '0; bus.wd[2] = 16'h7777;
      end
      beat(16'h0100 + 16'(i));
      bus.we = 1'b0;
    end
    chk("coll_done", bus.fill_done, 1);
    for (int l = 0; l < 16; l++) exp_v[l] = 16'h0100 + 16'(l);
    exp_v[4] = 16'hBEEF;
    exp_v[2] = 16'h7777;
    chk_reg("coll_reg7", 5'd7, exp_v);
    tick();

    // 5: reset mid-fill
    start_fill(5'd9);
    for (int i = 0; i < 6; i++) beat(16'h0200 + 16'(i));
    rst = 1'b1; #1;
    chk_reg("abort_reg7", 5'd7, '0);
    chk_reg("abort_reg9", 5'd9, '0);
    chk("abort_ready", bus.fill_ready, 0);
    chk("abort_busy", bus.fill_busy, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", bus.fill_done, 0);
    end
    start_fill(5'd9);
    for (int i = 0; i < 16; i++) beat(16'h0200 + 16'(i));
    chk("refill_done", bus.fill_done, 1);
    for (int l = 0; l < 16; l++) exp_v[l] = 16'h0200 + 16'(l);
    chk_reg("refill_reg9", 5'd9, exp_v);
    tick();

    // 6: fill_start held high through FILL and DONE
    bus.fill_start = 1'b1; bus.fill_reg = 5'd12;
    tick();
    bus.fill_reg = 5'd13;
    for (int i = 0; i < 16; i++) beat(16'h0300 + 16'(i));
    chk("held_done", bus.fill_done, 1);
    bus.fill_start = 1'b0;
    tick();
    chk("held_idle_busy", bus.fill_busy, 0);
    tick();
    chk("held_idle_ready", bus.fill_ready, 0);
    for (int l = 0; l < 16; l++) exp_v[l] = 16'h0300 + 16'(l);
    chk_reg("held_reg12", 5'd12, exp_v);
    chk_reg("held_reg13", 5'd13, '0);
    start_fill(5'd13);
    chk("new_fill_ready", bus.fill_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
